// File: rtl/product_acc_pkg.sv
// Shared definitions for the product accumulator: FSM encoding, default widths
// and the full-adder cell used by the ripple adder.
package product_acc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } acc_state_t;

  localparam int PROD_W_DEF  = 8;
  localparam int ACC_W_DEF   = 16;
  localparam int N_TERMS_DEF = 4;
  localparam int CNT_W       = 8;

  // One full-adder cell: returns {carry, sum}.
  function automatic logic [1:0] full_add(input logic a, input logic b, input logic cin);
    return {(a & b) | (a & cin) | (b & cin), a ^ b ^ cin};
  endfunction

endpackage

// File: rtl/product_accumulator_acc_adder.sv
// ACC_W-bit ripple-carry adder chained from full-adder cells; exposes the
// carry out of the top bit for overflow detection.
module acc_adder
  import product_acc_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  output logic [ACC_W-1:0] sum,
  output logic             cout
);

  logic [ACC_W:0] carry;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < ACC_W; i++) begin : g_fa
    assign {carry[i+1], sum[i]} = full_add(a[i], b[i], carry[i]);
  end

  assign cout = carry[ACC_W];

endmodule

// File: rtl/product_accumulator.sv
// Sums N_TERMS consecutive products into a registered result with an overflow flag.
// Define PRODUCT_ACC_SAT_EN to clamp the sum at 2^ACC_W-1 instead of wrapping.
module product_accumulator
  import product_acc_pkg::*;
#(
  parameter int PROD_W  = PROD_W_DEF,
  parameter int ACC_W   = ACC_W_DEF,
  parameter int N_TERMS = N_TERMS_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_ovf
);

`ifdef PRODUCT_ACC_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] N_LAST = N_TERMS[CNT_W-1:0];

  acc_state_t       state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf;

  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] add_sum;
  logic             add_cout;
  logic [ACC_W-1:0] acc_nxt;
  logic             ovf_nxt;
  logic [CNT_W-1:0] cnt_inc;
  logic             last;

  // Once a group has overflowed the clamp stays in force until the group ends.
  function automatic logic [ACC_W-1:0] sat_acc(input logic [ACC_W-1:0] s, input logic ovf_any);
    return (SAT_EN && ovf_any) ? {ACC_W{1'b1}} : s;
  endfunction

  assign in_ready = (state != DONE);
  assign prod_ext = ACC_W'(in_prod);
  assign cnt_inc  = cnt + CNT_W'(1);

  acc_adder #(
    .ACC_W (ACC_W)
  ) u_adder (
    .a    (acc),
    .b    (prod_ext),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_comb begin
    acc_nxt = prod_ext;
    ovf_nxt = 1'b0;
    last    = (N_LAST == CNT_W'(1));
    if (state == ACC) begin
      ovf_nxt = ovf | add_cout;
      acc_nxt = sat_acc(add_sum, ovf_nxt);
      last    = (cnt_inc == N_LAST);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_ovf   <= 1'b0;
    end else if (clr) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE, ACC: begin
          if (in_valid) begin
            acc <= acc_nxt;
            ovf <= ovf_nxt;
            cnt <= (state == IDLE) ? CNT_W'(1) : cnt_inc;
            if (last) begin
              state     <= DONE;
              out_valid <= 1'b1;
              out_sum   <= acc_nxt;
              out_ovf   <= ovf_nxt;
            end else begin
              state <= ACC;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_ovf   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Scoreboard bench for product_accumulator: default build, a 9-bit accumulator
// instance for overflow, and a single-term instance.
module tb_product_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic        in_valid;
  logic [7:0]  in_prod;
  logic        out_ready;

  logic        a_in_ready, a_out_valid, a_out_ovf;
  logic [15:0] a_out_sum;
  logic        b_in_ready, b_out_valid, b_out_ovf;
  logic [8:0]  b_out_sum;

  logic        c_valid, c_ready;
  logic [7:0]  c_prod;
  logic        c_in_ready, c_out_valid, c_out_ovf;
  logic [15:0] c_out_sum;

  int checks = 0;
  int errors = 0;

  logic [16:0] qa[$];
  logic [9:0]  qb[$];

  always #5 clk = ~clk;

  product_accumulator #(.PROD_W(8), .ACC_W(16), .N_TERMS(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_prod(in_prod), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_sum(a_out_sum), .out_ovf(a_out_ovf)
  );

  product_accumulator #(.PROD_W(8), .ACC_W(9), .N_TERMS(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_prod(in_prod), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_sum(b_out_sum), .out_ovf(b_out_ovf)
  );

  product_accumulator #(.PROD_W(8), .ACC_W(16), .N_TERMS(1)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(c_valid), .in_ready(c_in_ready),
    .in_prod(c_prod), .out_valid(c_out_valid), .out_ready(c_ready),
    .out_sum(c_out_sum), .out_ovf(c_out_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Hold in_valid until the shared instances accept, then idle for gap cycles.
  task automatic send(input logic [7:0] p, input int gap);
    int n;
    in_valid = 1'b1;
    in_prod  = p;
    n = 0;
    forever begin
      @(negedge clk);
      if (a_in_ready) break;
      n++;
      if (n > 100) begin
        chk("send_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic group(input logic [7:0] p0, input logic [7:0] p1, input logic [7:0] p2,
                       input logic [7:0] p3, input int gap, input bit push);
    int s;
    logic [8:0] bs;
    s = int'(p0) + int'(p1) + int'(p2) + int'(p3);
`ifdef PRODUCT_ACC_SAT_EN
    bs = (s > 511) ? 9'd511 : 9'(s);
`else
    bs = 9'(s % 512);
`endif
    if (push) begin
      qa.push_back({(s > 65535), 16'(s)});
      qb.push_back({(s > 511), bs});
    end
    send(p0, gap);
    send(p1, gap);
    send(p2, gap);
    send(p3, 0);
  endtask

  always @(negedge clk) begin
    if (rst_n && !clr && a_out_valid) chk("rdy_in_done", a_in_ready, 0);
    if (rst_n && !clr && a_out_valid && out_ready) begin
      logic [16:0] ea;
      logic [9:0]  eb;
      if (qa.size() == 0) begin
        chk("sb_a_empty", 1, 0);
      end else begin
        ea = qa.pop_front();
        chk("sum_a", a_out_sum, ea[15:0]);
        chk("ovf_a", a_out_ovf, ea[16]);
      end
      if (qb.size() == 0) begin
        chk("sb_b_empty", 1, 0);
      end else begin
        eb = qb.pop_front();
        chk("valid_b", b_out_valid, 1);
        chk("sum_b", b_out_sum, eb[8:0]);
        chk("ovf_b", b_out_ovf, eb[9]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_prod = '0; out_ready = 1'b0;
    c_valid = 1'b0; c_prod = '0; c_ready = 1'b0;

    // Reset state is visible before any clock edge.
    #2;
    chk("rst_valid", a_out_valid, 0);
    chk("rst_sum", a_out_sum, 0);
    chk("rst_ovf", a_out_ovf, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_ready", a_in_ready, 1);

    // Back-to-back group, consumer always ready; sum lands with out_valid.
    out_ready = 1'b1;
    group(8'd3, 8'd5, 8'd7, 8'd9, 0, 1'b1);
    chk("lat_valid", a_out_valid, 1);
    chk("lat_sum", a_out_sum, 24);
    @(posedge clk); #1;
    chk("idle_after_take", a_out_valid, 0);

    // Gapped input, consumer stalls three cycles in DONE; stray in_valid ignored.
    out_ready = 1'b0;
    group(8'd225, 8'd225, 8'd225, 8'd225, 2, 1'b1);
    chk("stall_valid", a_out_valid, 1);
    in_valid = 1'b1;
    in_prod  = 8'd77;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("stall_sum", a_out_sum, 900);
      chk("stall_ready", a_in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("rel_valid", a_out_valid, 0);
    chk("rel_ready", a_in_ready, 1);
    chk("rel_sum", a_out_sum, 0);

    // Overflow on the 9-bit instance (wrap or clamp per build).
    group(8'd225, 8'd225, 8'd225, 8'd0, 0, 1'b1);
    @(posedge clk); #1;

    // clr mid-group beats a pending product.
    send(8'd10, 0);
    send(8'd20, 0);
    clr = 1'b1; in_valid = 1'b1; in_prod = 8'd50;
    @(posedge clk); #1;
    clr = 1'b0; in_valid = 1'b0;
    chk("clr_valid", a_out_valid, 0);
    chk("clr_ready", a_in_ready, 1);
    group(8'd1, 8'd1, 8'd1, 8'd1, 0, 1'b1);
    @(posedge clk); #1;

    // clr together with out_ready in DONE discards the result.
    out_ready = 1'b0;
    group(8'd2, 8'd3, 8'd4, 8'd5, 0, 1'b0);
    chk("pre_clr_valid", a_out_valid, 1);
    clr = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    chk("clrdone_valid", a_out_valid, 0);
    chk("clrdone_sum", a_out_sum, 0);
    group(8'd1, 8'd2, 8'd3, 8'd4, 0, 1'b1);
    @(posedge clk); #1;

    // Asynchronous reset while a result is held.
    out_ready = 1'b0;
    group(8'd7, 8'd7, 8'd7, 8'd7, 0, 1'b0);
    chk("pre_rst_sum", a_out_sum, 28);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", a_out_valid, 0);
    chk("arst_sum", a_out_sum, 0);
    chk("arst_ovf", a_out_ovf, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;

    // Asynchronous reset mid-group discards the partial sum.
    send(8'd100, 0);
    send(8'd100, 0);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("arst_mid_valid", a_out_valid, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    group(8'd1, 8'd2, 8'd3, 8'd4, 0, 1'b1);
    @(posedge clk); #1;

    // Single-term instance completes after one accept.
    c_ready = 1'b1;
    c_valid = 1'b1;
    c_prod  = 8'd42;
    n = 0;
    forever begin
      @(negedge clk);
      if (c_in_ready) break;
      n++;
      if (n > 100) begin
        chk("c_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk); #1;
    c_valid = 1'b0;
    chk("c_valid", c_out_valid, 1);
    chk("c_sum", c_out_sum, 42);
    chk("c_ovf", c_out_ovf, 0);
    @(posedge clk); #1;
    chk("c_idle", c_out_valid, 0);

    repeat (2) @(posedge clk);
    chk("qa_drained", qa.size(), 0);
    chk("qb_drained", qb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
